// File: rtl/param_data_memory.sv
// Parameterised single-port-per-direction data memory with byte-masked writes,
// selectable read-during-write behaviour and a full-memory clear sweep that
// also runs automatically after reset.
module param_data_memory #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 6,
    parameter int DEPTH    = 64,
    parameter int RDW_MODE = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable_read,
    input  logic [ADDR_W-1:0]   address_read,
    input  logic                enable_write,
    input  logic [ADDR_W-1:0]   address_write,
    input  logic [DATA_W-1:0]   data_write,
    input  logic [DATA_W/8-1:0] write_mask,
    input  logic                clear_req,
    output logic [DATA_W-1:0]   data_read,
    output logic                read_valid,
    output logic                busy,
    output logic                addr_error
);

    localparam int NB = DATA_W / 8;
    // One extra bit so DEPTH == 2**ADDR_W is representable in the range check.
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   clr_addr_q, clr_addr_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                rvalid_q, rvalid_d;
    logic                aerr_q, aerr_d;

    logic [DATA_W-1:0]   mem [DEPTH];

    logic                mem_we;
    logic [ADDR_W-1:0]   mem_wa;
    logic [DATA_W-1:0]   mem_wd;

    logic                rd_acc, wr_acc, rd_inr, wr_inr, same_addr;
    logic [DATA_W-1:0]   rd_word, wr_word;

    // Replace only the bytes selected by the mask.
    function automatic logic [DATA_W-1:0] byte_merge(input logic [DATA_W-1:0] old_w,
                                                     input logic [DATA_W-1:0] new_w,
                                                     input logic [NB-1:0]     mask);
        logic [DATA_W-1:0] r;
        r = old_w;
        for (int b = 0; b < NB; b++) begin
            if (mask[b]) r[8*b +: 8] = new_w[8*b +: 8];
        end
        return r;
    endfunction

    // Access qualification and the candidate read / merged write words.
    always_comb begin
        rd_acc    = (state_q == IDLE) && enable_read;
        wr_acc    = (state_q == IDLE) && enable_write;
        rd_inr    = {1'b0, address_read}  < DEPTH_EXT;
        wr_inr    = {1'b0, address_write} < DEPTH_EXT;
        same_addr = (address_read == address_write);
        rd_word   = mem[address_read];
        wr_word   = byte_merge(mem[address_write], data_write, write_mask);
    end

    // Next-state, access handling and memory write port selection.
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        rdata_d    = rdata_q;
        rvalid_d   = 1'b0;
        aerr_d     = 1'b0;
        mem_we     = 1'b0;
        mem_wa     = address_write;
        mem_wd     = wr_word;
        case (state_q)
            IDLE: begin
                if (rd_acc) begin
                    rvalid_d = 1'b1;
                    if (rd_inr) begin
                        // New-data mode forwards the merged word of a colliding write.
                        if ((RDW_MODE != 0) && wr_acc && wr_inr && same_addr)
                            rdata_d = wr_word;
                        else
                            rdata_d = rd_word;
                    end else begin
                        rdata_d = '0;
                        aerr_d  = 1'b1;
                    end
                end
                if (wr_acc) begin
                    if (wr_inr) mem_we = 1'b1;
                    else        aerr_d = 1'b1;
                end
                // The access above completes on this edge; the sweep starts next.
                if (clear_req) begin
                    state_d    = CLEAR;
                    clr_addr_d = '0;
                end
            end
            CLEAR: begin
                mem_we = 1'b1;
                mem_wa = clr_addr_q;
                mem_wd = '0;
                if (clr_addr_q == LAST_ADDR) begin
                    state_d    = IDLE;
                    clr_addr_d = '0;
                end else begin
                    clr_addr_d = clr_addr_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and output registers; reset forces a fresh sweep from address 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= CLEAR;
            clr_addr_q <= '0;
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
            aerr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_d;
            aerr_q     <= aerr_d;
        end
    end

    // Storage array; no writes land while reset is held.
    always_ff @(posedge clk) begin
        if (!reset && mem_we) mem[mem_wa] <= mem_wd;
    end

    assign data_read  = rdata_q;
    assign read_valid = rvalid_q;
    assign addr_error = aerr_q;
    assign busy       = (state_q == CLEAR);

endmodule

// File: doc/param_data_memory.md
PARAM_DATA_MEMORY -- requirements
Module: param_data_memory

Interface
REQ-001 SHALL provide parameter DATA_W, default 16, word width in bits; must be a multiple of 8.
REQ-002 SHALL provide parameter ADDR_W, default 6, address width.
REQ-003 SHALL provide parameter DEPTH, default 64, number of words; 1 <= DEPTH <= 2**ADDR_W.
REQ-004 SHALL provide parameter RDW_MODE, default 0, same-address read-during-write behaviour: 0 = old data, 1 = new data.
REQ-005 SHALL use one clock and a synchronous, active-high reset, with ports as follows:
REQ-006 clk  in  1  rising-edge clock for all state.
REQ-007 reset  in  1  synchronous active-high reset.
REQ-008 enable_read  in  1  read request, sampled on clk.
REQ-009 address_read  in  ADDR_W  read word address.
REQ-010 enable_write  in  1  write request, sampled on clk.
REQ-011 address_write  in  ADDR_W  write word address.
REQ-012 data_write  in  DATA_W  write data.
REQ-013 write_mask  in  DATA_W/8  per-byte write enable; bit i covers data bits [8i+7:8i].
REQ-014 clear_req  in  1  one-cycle request to start a full-memory clear sweep.
REQ-015 data_read  out  DATA_W  registered read data.
REQ-016 read_valid  out  1  one-cycle pulse: data_read updated this cycle.
REQ-017 busy  out  1  clear sweep in progress; accesses ignored.
REQ-018 addr_error  out  1  one-cycle pulse: an accepted access targeted an address >= DEPTH.

Function
REQ-019 SHALL implement a two-state FSM, IDLE and CLEAR, plus a clear counter clr_addr of ADDR_W bits.
REQ-020 In CLEAR, each edge SHALL write all-zero to word clr_addr and increment clr_addr; the edge that clears DEPTH-1 SHALL set state IDLE and busy=0.
REQ-021 A clear sweep SHALL take exactly DEPTH edges; busy SHALL be 1 from the edge entering CLEAR through the last clearing edge.
REQ-022 In IDLE, clear_req=1 SHALL enter CLEAR on the next edge with clr_addr=0 and busy=1; clear_req in CLEAR SHALL be ignored.
REQ-023 Accesses SHALL be accepted only when busy=0. With busy=1, enable_read and enable_write are ignored: no memory change, read_valid=0, addr_error=0.
REQ-024 An accepted read SHALL drive data_read with the word at address_read and pulse read_valid on the same edge, i.e. 1-cycle latency.
REQ-025 data_read SHALL hold its value when no read is accepted.
REQ-026 An accepted write SHALL update only the bytes whose write_mask bit is 1; write_mask=0 SHALL leave the word unchanged.
REQ-027 On a same-edge read and write to the same in-range address, RDW_MODE=0 SHALL return the pre-write word.
REQ-028 On a same-edge read and write to the same in-range address, RDW_MODE=1 SHALL return the byte-merged post-write word.
REQ-029 An accepted access with address >= DEPTH SHALL pulse addr_error; such a write SHALL be dropped.
REQ-030 Such an out-of-range read SHALL return data_read=0 and SHALL still pulse read_valid.
REQ-031 If clear_req and an access occur on the same IDLE edge, the access SHALL complete first; the sweep SHALL follow.

Reset
REQ-032 reset=1 SHALL set state=CLEAR, clr_addr=0, busy=1, data_read=0, read_valid=0, addr_error=0.
REQ-033 While reset is held, clr_addr SHALL stay 0; after release, a full DEPTH-edge sweep SHALL run, so memory contents after reset are all-zero.
REQ-034 reset asserted mid-sweep or mid-access SHALL abort the operation and restart the sweep at address 0.

Verification
REQ-035 Reset release, defaults: busy=1 for exactly 64 edges, then 0; any read afterwards returns 0x0000 with read_valid pulse.
REQ-036 Write 0xBEEF to addr 5 with mask 2'b11, then mask 2'b01 with 0x1234 -> read addr 5 next cycle gives 0xBE34.
REQ-037 RDW_MODE=0 vs 1: addr 9 holds 0x1111; same-edge write 0x2222 and read addr 9 -> 0x1111 resp. 0x2222; the following read gives 0x2222 in both modes.
REQ-038 DEPTH=48: write 0xAAAA to addr 50 -> addr_error pulse, no memory change; read addr 50 -> data_read=0x0000, read_valid=1, addr_error=1.
REQ-039 Fill words with nonzero data, pulse clear_req -> busy high 64 edges; writes during busy are ignored; afterwards all reads return 0.
REQ-040 Assert reset 10 edges into a clear_req sweep -> on release, sweep restarts at 0 and busy drops 64 edges after release.
